// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer.
//   PC_W       : program counter width (10-bit instruction address space)
//   jump_t     : jump condition selector (JMP=0, JC=1, JZ=2, JNZ=3)
//   data_src_t : operand source type; SRC_INDIRECT needs a pointer-read cycle
//   state_t    : sequencer FSM states
//   jump_taken : jump condition evaluation against the current flags
package pc_sequencer_pkg;

    localparam int unsigned PC_W = 10;

    typedef enum logic [1:0] {
        JMP = 2'd0,
        JC  = 2'd1,
        JZ  = 2'd2,
        JNZ = 2'd3
    } jump_t;

    typedef enum logic [1:0] {
        SRC_NONE     = 2'd0,
        SRC_IMM      = 2'd1,
        SRC_DIRECT   = 2'd2,
        SRC_INDIRECT = 2'd3
    } data_src_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        INDIR  = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    function automatic logic jump_taken(jump_t cond, logic cy, logic z);
        logic taken;
        case (cond)
            JMP:     taken = 1'b1;
            JC:      taken = cy;
            JZ:      taken = z;
            JNZ:     taken = ~z;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer and the fetch/decode/datapath logic around it.
//   Decoder/memory -> sequencer : imem_ack, is_jump, call, ret, jump_cond,
//                                 data_src, operand, flag_cy, flag_z
//   Sequencer -> surroundings   : pc, imem_req, ir_load, ind_phase, exec_en,
//                                 halted, err_ovf, err_unf
// master: the sequencer side. slave: the surrounding core / memory side.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic            imem_ack;
    logic            is_jump;
    logic            call;
    logic            ret;
    jump_t           jump_cond;
    data_src_t       data_src;
    logic [PC_W-1:0] operand;
    logic            flag_cy;
    logic            flag_z;

    logic [PC_W-1:0] pc;
    logic            imem_req;
    logic            ir_load;
    logic            ind_phase;
    logic            exec_en;
    logic            halted;
    logic            err_ovf;
    logic            err_unf;

    modport master (
        input  imem_ack, is_jump, call, ret, jump_cond, data_src, operand,
               flag_cy, flag_z,
        output pc, imem_req, ir_load, ind_phase, exec_en, halted, err_ovf,
               err_unf
    );

    modport slave (
        output imem_ack, is_jump, call, ret, jump_cond, data_src, operand,
               flag_cy, flag_z,
        input  pc, imem_req, ir_load, ind_phase, exec_en, halted, err_ovf,
               err_unf
    );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Return-address stack (LIFO) for call/ret.
//   clk, rst : clock, synchronous active-high reset (pointer only)
//   push     : write wdata on top (caller guarantees !full)
//   pop      : discard top entry (caller guarantees !empty)
//   wdata    : return address to push
//   full     : DEPTH entries held
//   empty    : no entries held
//   top      : most recently pushed entry (undefined when empty)
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] wdata,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] top
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [AW:0]     cnt_q;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   top_idx;

    // Low bits of the count address the next free slot; when full they wrap
    // to 0, so top_idx still lands on DEPTH-1.
    assign wr_idx  = cnt_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign top     = mem_q[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push) begin
            cnt_q <= cnt_q + (AW+1)'(1);
        end else if (pop) begin
            cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: FETCH -> DECODE -> [INDIR] -> EXEC -> FETCH, with a
// return stack for call/ret and a sticky HALT on stack over/underflow.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : pc_sequencer_if.master (decoder controls and flags in; pc, fetch
//         request, ir_load, ind_phase, exec_en, halted, error flags out)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic            imem_req_q;
    logic            ind_phase_q;
    logic            exec_en_q;
    logic            halted_q;
    logic            err_ovf_q;
    logic            err_unf_q;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_d;
    logic            halt_d;
    logic            err_ovf_d;
    logic            err_unf_d;

    logic            stk_push;
    logic            stk_pop;
    logic            stk_full;
    logic            stk_empty;
    logic [PC_W-1:0] stk_top;

    return_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (pc_inc),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    // EXEC-cycle pc resolution; ret outranks call, call outranks jumps.
    // A stack error leaves pc on the faulting instruction.
    always_comb begin
        pc_inc    = pc_q + PC_W'(1);
        pc_d      = pc_inc;
        halt_d    = 1'b0;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        if (state_q == EXEC) begin
            if (bus.ret) begin
                if (stk_empty) begin
                    pc_d      = pc_q;
                    halt_d    = 1'b1;
                    err_unf_d = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    pc_d    = stk_top;
                end
            end else if (bus.call) begin
                if (stk_full) begin
                    pc_d      = pc_q;
                    halt_d    = 1'b1;
                    err_ovf_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    pc_d     = bus.operand;
                end
            end else if (bus.is_jump &&
                         jump_taken(bus.jump_cond, bus.flag_cy, bus.flag_z)) begin
                pc_d = bus.operand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            imem_req_q  <= 1'b1;
            ind_phase_q <= 1'b0;
            exec_en_q   <= 1'b0;
            halted_q    <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ack) begin
                        state_q    <= DECODE;
                        imem_req_q <= 1'b0;
                    end
                end
                DECODE: begin
                    if (bus.data_src == SRC_INDIRECT) begin
                        state_q     <= INDIR;
                        ind_phase_q <= 1'b1;
                    end else begin
                        state_q   <= EXEC;
                        exec_en_q <= 1'b1;
                    end
                end
                INDIR: begin
                    state_q     <= EXEC;
                    ind_phase_q <= 1'b0;
                    exec_en_q   <= 1'b1;
                end
                EXEC: begin
                    exec_en_q <= 1'b0;
                    pc_q      <= pc_d;
                    err_ovf_q <= err_ovf_d;
                    err_unf_q <= err_unf_d;
                    if (halt_d) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                HALT: begin
                end
                default: begin
                    state_q     <= HALT;
                    halted_q    <= 1'b1;
                    imem_req_q  <= 1'b0;
                    ind_phase_q <= 1'b0;
                    exec_en_q   <= 1'b0;
                end
            endcase
        end
    end

    // ir_load must coincide with the ack cycle, so it cannot be registered.
    assign bus.ir_load   = (state_q == FETCH) && bus.imem_ack;
    assign bus.pc        = pc_q;
    assign bus.imem_req  = imem_req_q;
    assign bus.ind_phase = ind_phase_q;
    assign bus.exec_en   = exec_en_q;
    assign bus.halted    = halted_q;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_unf   = err_unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    typedef struct {
        bit         is_rst;
        logic [9:0] pc;
        logic       ovf;
        logic       unf;
        logic       halt;
        int         len;
        int         req;
        int         ind;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pc_sequencer_if bus();

    pc_sequencer #(.STACK_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: samples on the falling edge and scores against the queue.
    initial begin
        int   tot, req, ind, ld;
        bit   pending, rst_seen;
        exp_t e;
        tot = 0; req = 0; ind = 0; ld = 0;
        pending = 0; rst_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tot = 0; req = 0; ind = 0; ld = 0;
                pending = 0; rst_seen = 1;
            end else begin
                if (rst_seen) begin
                    rst_seen = 0;
                    if (q.size() == 0 || !q[0].is_rst) begin
                        chk("rst_expectation_present", 0, 1);
                    end else begin
                        e = q.pop_front();
                        chk("rst_pc", int'(bus.pc), int'(e.pc));
                        chk("rst_imem_req", int'(bus.imem_req), 1);
                        chk("rst_strobes", int'({bus.exec_en, bus.ind_phase}), 0);
                        chk("rst_halted", int'(bus.halted), 0);
                        chk("rst_err", int'({bus.err_ovf, bus.err_unf}), 0);
                    end
                end
                if (pending) begin
                    pending = 0;
                    if (q.size() == 0 || q[0].is_rst) begin
                        chk("instr_expectation_present", 0, 1);
                    end else begin
                        e = q.pop_front();
                        chk("pc", int'(bus.pc), int'(e.pc));
                        chk("err_ovf", int'(bus.err_ovf), int'(e.ovf));
                        chk("err_unf", int'(bus.err_unf), int'(e.unf));
                        chk("halted", int'(bus.halted), int'(e.halt));
                        chk("instr_cycles", tot, e.len);
                        chk("imem_req_cycles", req, e.req);
                        chk("ind_phase_cycles", ind, e.ind);
                        chk("ir_load_pulses", ld, 1);
                    end
                    tot = 0; req = 0; ind = 0; ld = 0;
                end
                tot++;
                req += int'(bus.imem_req);
                ind += int'(bus.ind_phase);
                ld  += int'(bus.ir_load);
                if (bus.halted) begin
                    chk("halt_strobes",
                        int'({bus.imem_req, bus.exec_en, bus.ind_phase, bus.ir_load}), 0);
                end
                if (bus.exec_en) pending = 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 50) begin
            step();
            n++;
        end
        if (!bus.imem_req) begin
            checks++;
            errors++;
            $display("FAIL wait_req: imem_req=0 after 50 cycles, required 1");
        end
    endtask

    task automatic do_reset(input int unsigned cyc);
        exp_t e;
        e.is_rst = 1; e.pc = '0; e.ovf = 0; e.unf = 0; e.halt = 0;
        e.len = 0; e.req = 0; e.ind = 0;
        q.push_back(e);
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        repeat (cyc) step();
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic j, input logic c, input logic r,
                             input jump_t jc, input data_src_t ds,
                             input logic [9:0] op, input logic cy, input logic z,
                             input int unsigned dly, input int unsigned hold,
                             input logic [9:0] epc, input logic eovf,
                             input logic eunf);
        exp_t e;
        int   n;
        wait_req();
        bus.is_jump   = j;
        bus.call      = c;
        bus.ret       = r;
        bus.jump_cond = jc;
        bus.data_src  = ds;
        bus.operand   = op;
        bus.flag_cy   = cy;
        bus.flag_z    = z;
        e.is_rst = 0;
        e.pc     = epc;
        e.ovf    = eovf;
        e.unf    = eunf;
        e.halt   = eovf | eunf;
        e.ind    = (ds == SRC_INDIRECT) ? 1 : 0;
        e.len    = 3 + int'(dly) + e.ind;
        e.req    = 1 + int'(dly);
        q.push_back(e);
        bus.imem_ack = 1'b0;
        repeat (dly) step();
        bus.imem_ack = 1'b1;
        repeat (hold) step();
        bus.imem_ack = 1'b0;
        n = 0;
        while (!(bus.imem_req || bus.halted) && n < 20) begin
            step();
            n++;
        end
        if (!(bus.imem_req || bus.halted)) begin
            checks++;
            errors++;
            $display("FAIL instr_done: no return to FETCH/HALT within 20 cycles");
        end
    endtask

    task automatic nop(input int unsigned dly, input int unsigned hold,
                       input logic [9:0] epc);
        run_instr(0, 0, 0, JMP, SRC_IMM, 10'h000, 0, 0, dly, hold, epc, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_ack = 0; bus.is_jump = 0; bus.call = 0; bus.ret = 0;
        bus.jump_cond = JMP; bus.data_src = SRC_IMM; bus.operand = '0;
        bus.flag_cy = 0; bus.flag_z = 0;

        do_reset(2);
        nop(3, 1, 10'h001);                                          // ack after 3 waits
        run_instr(1, 0, 0, JZ,  SRC_IMM, 10'h155, 0, 1, 0, 1, 10'h155, 0, 0);
        run_instr(1, 0, 0, JZ,  SRC_IMM, 10'h155, 0, 0, 0, 1, 10'h156, 0, 0);
        run_instr(1, 0, 0, JNZ, SRC_IMM, 10'h02A, 1, 0, 0, 1, 10'h02A, 0, 0);
        run_instr(1, 0, 0, JC,  SRC_IMM, 10'h100, 0, 1, 0, 1, 10'h02B, 0, 0);
        run_instr(1, 0, 0, JC,  SRC_IMM, 10'h100, 1, 0, 0, 1, 10'h100, 0, 0);
        run_instr(0, 0, 0, JMP, SRC_INDIRECT, 10'h000, 0, 0, 0, 1, 10'h101, 0, 0);
        nop(0, 3, 10'h102);                                          // ack held past FETCH
        run_instr(1, 0, 0, JMP, SRC_IMM, 10'h3FF, 0, 0, 0, 1, 10'h3FF, 0, 0);
        run_instr(0, 1, 0, JMP, SRC_IMM, 10'h200, 0, 0, 0, 1, 10'h200, 0, 0);
        run_instr(0, 0, 1, JMP, SRC_IMM, 10'h000, 0, 0, 0, 1, 10'h000, 0, 0);
        run_instr(0, 0, 0, JMP, SRC_IMM, 10'h123, 1, 1, 0, 1, 10'h001, 0, 0);
        run_instr(0, 1, 0, JMP, SRC_IMM, 10'h050, 0, 0, 0, 1, 10'h050, 0, 0);
        run_instr(0, 1, 0, JMP, SRC_IMM, 10'h060, 0, 0, 0, 1, 10'h060, 0, 0);
        run_instr(0, 0, 1, JMP, SRC_IMM, 10'h000, 0, 0, 0, 1, 10'h051, 0, 0);
        run_instr(0, 0, 1, JMP, SRC_IMM, 10'h000, 0, 0, 0, 1, 10'h002, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_instr(0, 1, 0, JMP, SRC_IMM, 10'h010 + 10'(i), 0, 0, 0, 1,
                      10'h010 + 10'(i), 0, 0);
        end
        run_instr(0, 1, 0, JMP, SRC_IMM, 10'h300, 0, 0, 0, 1, 10'h017, 1, 0);
        bus.imem_ack = 1'b1;                                         // ignored in HALT
        repeat (4) step();
        bus.imem_ack = 1'b0;
        do_reset(1);
        run_instr(0, 0, 1, JMP, SRC_IMM, 10'h000, 0, 0, 0, 1, 10'h000, 0, 1);
        repeat (2) step();
        do_reset(1);
        run_instr(1, 0, 0, JMP, SRC_IMM, 10'h0AA, 0, 0, 0, 1, 10'h0AA, 0, 0);
        wait_req();                                                  // reset during INDIR
        bus.is_jump = 0; bus.call = 0; bus.ret = 0;
        bus.data_src = SRC_INDIRECT;
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        step();
        do_reset(1);
        nop(0, 1, 10'h001);
        wait_req();                                                  // reset mid FETCH wait
        repeat (2) step();
        do_reset(1);
        nop(0, 1, 10'h001);
        repeat (3) step();
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have clock and reset ports clk and rst; one clock; rst is synchronous and active-high.
REQ-002 Parameter: STACK_DEPTH, default 8, return-stack entries (power of two, 2..16).
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 imem_ack  in  1  instruction word valid this cycle.
REQ-006 is_jump, call, ret  in  1 each  decoder control outputs for the held instruction.
REQ-007 jump_cond  in  jump_t (2)  jump type.
REQ-008 data_src  in  data_src_t (2)  operand type.
REQ-009 operand  in  10  instruction bits [9:0], used as jump target.
REQ-010 flag_cy, flag_z  in  1 each  current carry and zero flags.
REQ-011 pc  out  10  address of the instruction being fetched or executed.
REQ-012 imem_req  out  1  instruction fetch request.
REQ-013 ir_load  out  1  strobe that captures the instruction word.
REQ-014 ind_phase  out  1  pointer-register read cycle for indirect operands.
REQ-015 exec_en  out  1  qualifies decoder ce_* enables; datapath writes only when high.
REQ-016 halted  out  1  sequencer stopped on a stack error.
REQ-017 err_ovf, err_unf  out  1 each  sticky return-stack overflow / underflow.

Function
REQ-018 States SHALL be FETCH, DECODE, INDIR, EXEC, HALT.
REQ-019 FETCH: imem_req=1; stay until imem_ack=1; on ack, ir_load=1 in the same cycle, then go to DECODE.
REQ-020 DECODE: one cycle, no outputs active; data_src==SRC_INDIRECT -> INDIR, otherwise -> EXEC.
REQ-021 INDIR: ind_phase=1 for exactly one cycle, then go to EXEC.
REQ-022 EXEC: exec_en=1 for exactly one cycle, pc updated at the cycle end, then go to FETCH.
REQ-023 Jump taken SHALL be decided by jump_cond: JMP always; JC when flag_cy=1; JZ when flag_z=1; JNZ when flag_z=0.
REQ-024 EXEC pc update priority: ret -> pc=top of stack, pop; call -> push pc+1, pc=operand; taken jump -> pc=operand; else pc=pc+1.
REQ-025 pc+1 SHALL wrap 1023->0, including the pushed return address.
REQ-026 call with stack full: no push, pc unchanged, err_ovf=1, go to HALT instead of FETCH.
REQ-027 ret with stack empty: pc unchanged, err_unf=1, go to HALT.
REQ-028 HALT: all strobes 0, halted=1; left only by rst.
REQ-029 Minimum instruction time: 3 cycles direct, 4 indirect, plus imem wait cycles.
REQ-030 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-031 rst SHALL force state FETCH, pc=0, stack empty, halted=0, err_ovf=0, err_unf=0.
REQ-032 rst SHALL win in any state, including mid-wait in FETCH and HALT; imem_req becomes 1 in the first cycle after rst deasserts.
REQ-033 Stack storage contents need no reset; only the pointer is reset.

Structure
REQ-034 jump_t, data_src_t and the state enum SHALL be in the shared enums package; jump_t encoding: JMP=0, JC=1, JZ=2, JNZ=3.
REQ-035 The return stack SHALL be a sub-module, return_stack, with push, pop, full, empty, top.

Verification
REQ-036 rst, then imem_ack delayed 3 cycles on a NOP -> imem_req high for 4 cycles, exec_en pulses once, pc goes 0->1.
REQ-037 JZ with operand=0x155: flag_z=1 -> pc=0x155; flag_z=0 -> pc=pc+1.
REQ-038 call 0x200 at pc=0x3FF, then ret -> pc=0x200, then pc=0x000 (wrapped return address).
REQ-039 Nine nested calls, STACK_DEPTH=8 -> ninth call sets err_ovf and halted, pc holds the ninth call's address; ret at reset -> err_unf.
REQ-040 Indirect instruction -> ind_phase exactly 1 cycle between DECODE and EXEC; total 4 cycles with immediate ack.
REQ-041 rst asserted in INDIR and in HALT -> next cycle state FETCH, pc=0, flags cleared.
